datapath_router_mt: RTL and testbench
=====================================

# datapath_router_mt

Shares one pipelined execution datapath among `PORTS` worker threads. Generalises the single-outstanding router: up to `MAX_INFLIGHT` instructions in flight, a valid/ready issue handshake, round-robin arbitration and in-order result return via a port-tag FIFO. Sits between the per-thread neuroevolution workers and the shared arithmetic datapath.

## Interface
- `PORTS`, 4: number of requesting threads, 2..64.
- `INSTR_W`, 32: instruction width.
- `RESULT_W`, 32: result width.
- `MAX_INFLIGHT`, 4: tag FIFO depth, power of two, 2..16.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instruction` in `INSTR_W*PORTS`: per-port instruction; port p occupies bits `[p*INSTR_W +: INSTR_W]`.
- `start` in `PORTS`: per-port one-cycle request strobe.
- `result` out `RESULT_W*PORTS`: per-port last result, same packing.
- `finished` out `PORTS`: per-port idle/done flag.
- `instruction_dp` out `INSTR_W`: instruction to datapath.
- `start_dp` out 1: issue valid.
- `ready_dp` in 1: datapath accepts issue.
- `result_dp` in `RESULT_W`: datapath result.
- `finished_dp` in 1: one-cycle result valid, results in issue order.
- `err_orphan` out 1: sticky; `finished_dp` seen with FIFO empty.

## Operation
- Per-port state: IDLE (finished=1), PENDING (instruction latched, not issued), INFLIGHT (issued, awaiting result).
- IDLE + `start[p]`: latch `instruction[p]` into pending register, `finished[p]`<=0, -> PENDING. `start[p]` in PENDING/INFLIGHT ignored.
- Arbiter: if no issue outstanding on outputs and FIFO not full, grant first PENDING port searching from `ptr+1` with wrap to 0; load `instruction_dp`, assert `start_dp`; `ptr`<=granted.
- Transfer when `start_dp && ready_dp` at an edge: push port index into tag FIFO, port -> INFLIGHT, `start_dp` drops unless a new grant loads in the same edge.
- `start_dp` held, `instruction_dp` stable until transfer.
- `finished_dp`: pop FIFO head p, write `result_dp` into slot p, `finished[p]`<=1, p -> IDLE. Other slots unchanged.
- FIFO empty on `finished_dp`: ignore data, set `err_orphan`.
- Simultaneous push and pop: both occur, count unchanged; allowed when full.
- Return to p and `start[p]` same edge: result written; new start accepted next cycle (p is IDLE only after this edge).

## Timing
- Reset values: `result`=0, `finished`=all ones, `instruction_dp`=0, `start_dp`=0, `err_orphan`=0, `ptr`=`PORTS-1` (port 0 first), FIFO empty, all ports IDLE.
- All outputs registered.
- `start[p]` at edge t -> `start_dp` earliest after edge t+1.
- Back-to-back issue: one transfer per cycle when `ready_dp` stays high and FIFO has room.
- `finished_dp` at edge t -> `result`/`finished` updated after edge t.
- Reset mid-operation: all in-flight tags discarded; late `finished_dp` after reset sets `err_orphan`.
- Tag width `max(1,$clog2(PORTS))`; FIFO count width `$clog2(MAX_INFLIGHT)+1`.

## Configuration
- `DATAPATH_ROUTER_PERF_EN` defined: adds outputs `perf_issued` (32 b, transfers) and `perf_stall` (32 b, cycles with `start_dp && !ready_dp` or a PENDING port blocked by full FIFO); both wrap at 2^32, reset 0.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Package `router_pkg`: `INSTR_W`/`RESULT_W` defaults, `port_state_t` enum (IDLE, PENDING, INFLIGHT), tag-width helper function.
- Sub-module `router_tag_fifo`: synchronous FIFO, parameters `DEPTH`, `W`; push/pop/full/empty/count; simultaneous push+pop legal when full.
- Top holds per-port state, pending registers, round-robin arbiter, result slots.

## Test plan
- Single request: PORTS=4, `start[2]` with 0x11, `ready_dp`=1, datapath returns 0x99 after 3 cycles -> one `start_dp` with 0x11, `result[2]`=0x99, `finished`=4'b1111.
- Fairness: all four start same cycle, `ready_dp`=1 -> issue order 0,1,2,3; next round after ptr=1 begins at port 2.
- Backpressure: `ready_dp`=0 for 5 cycles -> `start_dp` held, `instruction_dp` stable, no FIFO push; transfer on first ready cycle.
- FIFO full: MAX_INFLIGHT=2, 4 pending, no returns -> exactly 2 issues; `finished_dp` with push same edge -> third issues, count stays 2, results routed in issue order.
- Orphan and busy: `finished_dp` after reset -> `err_orphan`=1, results unchanged; `start[1]` while INFLIGHT -> ignored, only one issue.
- Reset mid-flight: 3 in flight, assert `reset` -> all outputs at reset values immediately, FIFO empty.

Source files
------------

// File: rtl/datapath_router_mt_pkg.sv
// Shared types for the multi-thread datapath router.
// Port state encoding and the tag-width helper.
package router_pkg;

  localparam int INSTR_W_DEF  = 32;
  localparam int RESULT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2
  } port_state_t;

  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/datapath_router_mt_if.sv
// Issue/return handshake between the router and
// the shared arithmetic datapath.
interface datapath_router_mt_if
  import router_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESULT_W = RESULT_W_DEF
);

  logic [INSTR_W-1:0]  instruction_dp;
  logic                start_dp;
  logic                ready_dp;
  logic [RESULT_W-1:0] result_dp;
  logic                finished_dp;

  modport master (
    output instruction_dp, start_dp,
    input  ready_dp, result_dp, finished_dp
  );

  modport slave (
    input  instruction_dp, start_dp,
    output ready_dp, result_dp, finished_dp
  );

endinterface

// File: rtl/datapath_router_mt_fifo.sv
// Port-tag FIFO; push and pop in one cycle are
// legal even when full.
module router_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_push);
      rp_q  <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/datapath_router_mt.sv
// Round-robin router of PORTS threads onto one pipelined datapath.
// Define DATAPATH_ROUTER_PERF_EN for issue/stall counters.
module datapath_router_mt
  import router_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int INSTR_W      = INSTR_W_DEF,
  parameter int RESULT_W     = RESULT_W_DEF,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [INSTR_W*PORTS-1:0]  instruction,
  input  logic [PORTS-1:0]          start,
  output logic [RESULT_W*PORTS-1:0] result,
  output logic [PORTS-1:0]          finished,
  output logic                      err_orphan,
`ifdef DATAPATH_ROUTER_PERF_EN
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_stall,
`endif
  datapath_router_mt_if.master      dp
);

  localparam int TW = tag_w(PORTS);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  port_state_t         state_q [PORTS];
  logic [INSTR_W-1:0]  pend_q  [PORTS];
  logic [RESULT_W-1:0] res_q   [PORTS];
  logic [PORTS-1:0]    fin_q;
  logic [INSTR_W-1:0]  idp_q;
  logic                sdp_q;
  logic [TW-1:0]       tag_q;
  logic [TW-1:0]       ptr_q;
  logic                err_q;

  logic [TW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          xfer;
  logic          pop_ok;
  logic          slot_free;
  logic          gnt_vld;
  logic [TW-1:0] gnt_idx;
  logic          grant;
  int            idx;

  assign xfer    = sdp_q && dp.ready_dp;
  assign pop_ok  = dp.finished_dp && !fifo_empty;
  assign cnt_nxt = fifo_cnt + CW'(xfer) - CW'(pop_ok);

  // Never let FIFO entries plus the held issue exceed the depth.
  assign slot_free = sdp_q ? (xfer && int'(cnt_nxt) < MAX_INFLIGHT)
                           : (!fifo_full || pop_ok);
  assign grant = gnt_vld && slot_free;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = PORTS; i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % PORTS;
      if (state_q[idx] == PENDING &&
          !(sdp_q && TW'(idx) == tag_q)) begin
        gnt_vld = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
  end

  router_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (xfer),
    .din_i   (tag_q),
    .pop_i   (pop_ok),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PORTS; p++) begin
        state_q[p] <= IDLE;
        pend_q[p]  <= '0;
        res_q[p]   <= '0;
      end
      fin_q <= '1;
      idp_q <= '0;
      sdp_q <= 1'b0;
      tag_q <= '0;
      ptr_q <= TW'(PORTS - 1);
      err_q <= 1'b0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        unique case (state_q[p])
          IDLE: if (start[p]) begin
            state_q[p] <= PENDING;
            pend_q[p]  <= instruction[p*INSTR_W +: INSTR_W];
            fin_q[p]   <= 1'b0;
          end
          PENDING: if (xfer && tag_q == TW'(p)) begin
            state_q[p] <= INFLIGHT;
          end
          INFLIGHT: if (pop_ok && fifo_head == TW'(p)) begin
            state_q[p] <= IDLE;
            res_q[p]   <= dp.result_dp;
            fin_q[p]   <= 1'b1;
          end
          default: ;
        endcase
      end
      if (grant) begin
        idp_q <= pend_q[gnt_idx];
        sdp_q <= 1'b1;
        tag_q <= gnt_idx;
        ptr_q <= gnt_idx;
      end else if (xfer) begin
        sdp_q <= 1'b0;
      end
      if (dp.finished_dp && fifo_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    result = '0;
    for (int p = 0; p < PORTS; p++) begin
      result[p*RESULT_W +: RESULT_W] = res_q[p];
    end
  end

  assign finished          = fin_q;
  assign err_orphan        = err_q;
  assign dp.instruction_dp = idp_q;
  assign dp.start_dp       = sdp_q;

`ifdef DATAPATH_ROUTER_PERF_EN
  logic [31:0] perf_iss_q;
  logic [31:0] perf_stl_q;
  logic        any_pend;

  always_comb begin
    any_pend = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (state_q[p] == PENDING) any_pend = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_iss_q <= '0;
      perf_stl_q <= '0;
    end else begin
      perf_iss_q <= perf_iss_q + 32'(xfer);
      if ((sdp_q && !dp.ready_dp) || (any_pend && fifo_full)) begin
        perf_stl_q <= perf_stl_q + 32'd1;
      end
    end
  end

  assign perf_issued = perf_iss_q;
  assign perf_stall  = perf_stl_q;
`endif

endmodule

// File: tb/tb_datapath_router_mt.sv
// Directed bench for datapath_router_mt with PORTS=4,
// MAX_INFLIGHT=2.
module tb_datapath_router_mt;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] instruction;
  logic [3:0]   start;
  logic [127:0] result;
  logic [3:0]   finished;
  logic         err_orphan;
`ifdef DATAPATH_ROUTER_PERF_EN
  logic [31:0]  perf_issued;
  logic [31:0]  perf_stall;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] logq [$];

  datapath_router_mt_if #(.INSTR_W(32), .RESULT_W(32)) dp ();

  datapath_router_mt #(
    .PORTS        (4),
    .INSTR_W      (32),
    .RESULT_W     (32),
    .MAX_INFLIGHT (2)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .instruction (instruction),
    .start       (start),
    .result      (result),
    .finished    (finished),
    .err_orphan  (err_orphan),
`ifdef DATAPATH_ROUTER_PERF_EN
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .dp          (dp)
  );

  always #5 clk = ~clk;

  // Record every accepted issue just before the edge that takes it.
  always begin
    @(negedge clk);
    #4;
    if (!rst && dp.start_dp === 1'b1 && dp.ready_dp === 1'b1)
      logq.push_back(dp.instruction_dp);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic run_ret(input int base, input int n);
    int ret;
    ret = 0;
    repeat (n) begin
      if (logq.size() - base > ret) begin
        dp.finished_dp = 1'b1;
        dp.result_dp   = logq[base+ret] + 32'h1000;
        ret++;
      end else begin
        dp.finished_dp = 1'b0;
      end
      tick(1);
    end
    dp.finished_dp = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (result !== 128'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", result); end
    checks++; if (finished !== 4'hF) begin failures++; $display("FAIL rst_finished got=%b exp=1111", finished); end
    checks++; if (dp.start_dp !== 1'b0) begin failures++; $display("FAIL rst_start_dp got=%b exp=0", dp.start_dp); end
    checks++; if (dp.instruction_dp !== 32'd0) begin failures++; $display("FAIL rst_instr_dp got=%h exp=0", dp.instruction_dp); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_orphan); end
    checks++; if (dut.fifo_cnt !== 2'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", dut.fifo_cnt); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    int base;
    base = logq.size();
    dp.ready_dp = 1'b1;
    instruction[2*32 +: 32] = 32'h11;
    start = 4'b0100;
    tick(1);
    start = 4'b0000;
    checks++; if (finished !== 4'b1011) begin failures++; $display("FAIL single_pend got=%b exp=1011", finished); end
    checks++; if (dp.start_dp !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", dp.start_dp); end
    tick(1);
    checks++; if (dp.start_dp !== 1'b1 || dp.instruction_dp !== 32'h11) begin failures++; $display("FAIL single_issue got=%b/%h exp=1/11", dp.start_dp, dp.instruction_dp); end
    tick(1);
    checks++; if (dp.start_dp !== 1'b0 || dut.fifo_cnt !== 2'd1) begin failures++; $display("FAIL single_xfer got=%b/%0d exp=0/1", dp.start_dp, dut.fifo_cnt); end
    tick(2);
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h99;
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (result[2*32 +: 32] !== 32'h99) begin failures++; $display("FAIL single_res got=%h exp=99", result[2*32 +: 32]); end
    checks++; if (finished !== 4'hF) begin failures++; $display("FAIL single_fin got=%b exp=1111", finished); end
    checks++; if (logq.size() - base != 1 || logq[base] !== 32'h11) begin failures++; $display("FAIL single_count got=%0d exp=1", logq.size() - base); end
  endtask

  task automatic test_fairness();
    int base;
    logic [31:0] exp2 [4];
    do_reset();
    base = logq.size();
    dp.ready_dp = 1'b1;
    for (int p = 0; p < 4; p++) instruction[p*32 +: 32] = 32'hA0 + p;
    start = 4'hF;
    tick(1);
    start = 4'h0;
    run_ret(base, 14);
    checks++; if (logq.size() - base != 4) begin failures++; $display("FAIL fair_count got=%0d exp=4", logq.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (logq[base+i] !== 32'hA0 + i) begin failures++; $display("FAIL fair_order%0d got=%h exp=%h", i, logq[base+i], 32'hA0 + i); end
      checks++; if (result[i*32 +: 32] !== 32'h10A0 + i) begin failures++; $display("FAIL fair_res%0d got=%h exp=%h", i, result[i*32 +: 32], 32'h10A0 + i); end
    end
    checks++; if (finished !== 4'hF) begin failures++; $display("FAIL fair_fin got=%b exp=1111", finished); end
    // Leave the pointer on port 1, then start everyone again.
    base = logq.size();
    instruction[1*32 +: 32] = 32'hC1;
    start = 4'b0010;
    tick(1);
    start = 4'h0;
    run_ret(base, 8);
    base = logq.size();
    for (int p = 0; p < 4; p++) instruction[p*32 +: 32] = 32'hD0 + p;
    start = 4'hF;
    tick(1);
    start = 4'h0;
    run_ret(base, 14);
    exp2[0] = 32'hD2; exp2[1] = 32'hD3; exp2[2] = 32'hD0; exp2[3] = 32'hD1;
    checks++; if (logq.size() - base != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", logq.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (logq[base+i] !== exp2[i]) begin failures++; $display("FAIL rr_order%0d got=%h exp=%h", i, logq[base+i], exp2[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = logq.size();
    dp.ready_dp = 1'b0;
    instruction[3*32 +: 32] = 32'h33;
    start = 4'b1000;
    tick(1);
    start = 4'h0;
    tick(1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dp.start_dp !== 1'b1 || dp.instruction_dp !== 32'h33 ||
          dut.fifo_cnt !== 2'd0 || logq.size() != base) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%h/%0d exp=1/33/0", c, dp.start_dp, dp.instruction_dp, dut.fifo_cnt);
      end
      tick(1);
    end
    dp.ready_dp = 1'b1;
    tick(1);
    checks++; if (dp.start_dp !== 1'b0 || dut.fifo_cnt !== 2'd1) begin failures++; $display("FAIL bp_xfer got=%b/%0d exp=0/1", dp.start_dp, dut.fifo_cnt); end
    checks++; if (logq.size() - base != 1 || logq[base] !== 32'h33) begin failures++; $display("FAIL bp_once got=%0d exp=1", logq.size() - base); end
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h77;
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (result[3*32 +: 32] !== 32'h77 || finished !== 4'hF) begin failures++; $display("FAIL bp_res got=%h/%b exp=77/1111", result[3*32 +: 32], finished); end
  endtask

  task automatic test_fifo_full();
    int base;
    do_reset();
    base = logq.size();
    dp.ready_dp = 1'b1;
    for (int p = 0; p < 4; p++) instruction[p*32 +: 32] = 32'hE0 + p;
    start = 4'hF;
    tick(1);
    start = 4'h0;
    tick(5);
    checks++; if (logq.size() - base != 2) begin failures++; $display("FAIL full_issues got=%0d exp=2", logq.size() - base); end
    checks++; if (dut.fifo_cnt !== 2'd2 || dp.start_dp !== 1'b0) begin failures++; $display("FAIL full_stop got=%0d/%b exp=2/0", dut.fifo_cnt, dp.start_dp); end
    checks++; if (finished !== 4'h0) begin failures++; $display("FAIL full_fin got=%b exp=0000", finished); end
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h200;
    tick(1);
    dp.result_dp   = 32'h201;
    checks++; if (result[0 +: 32] !== 32'h200) begin failures++; $display("FAIL full_res0 got=%h exp=200", result[0 +: 32]); end
    checks++; if (dp.start_dp !== 1'b1 || dp.instruction_dp !== 32'hE2 || dut.fifo_cnt !== 2'd1) begin failures++; $display("FAIL full_third got=%b/%h/%0d exp=1/e2/1", dp.start_dp, dp.instruction_dp, dut.fifo_cnt); end
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (dut.fifo_cnt !== 2'd1) begin failures++; $display("FAIL full_pushpop got=%0d exp=1", dut.fifo_cnt); end
    checks++; if (result[1*32 +: 32] !== 32'h201 || dp.instruction_dp !== 32'hE3) begin failures++; $display("FAIL full_res1 got=%h/%h exp=201/e3", result[1*32 +: 32], dp.instruction_dp); end
    tick(1);
    checks++; if (dut.fifo_cnt !== 2'd2 || dp.start_dp !== 1'b0) begin failures++; $display("FAIL full_again got=%0d/%b exp=2/0", dut.fifo_cnt, dp.start_dp); end
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h202;
    tick(1);
    dp.result_dp   = 32'h203;
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (result[2*32 +: 32] !== 32'h202 || result[3*32 +: 32] !== 32'h203) begin failures++; $display("FAIL full_res23 got=%h/%h exp=202/203", result[2*32 +: 32], result[3*32 +: 32]); end
    checks++; if (finished !== 4'hF || dut.fifo_cnt !== 2'd0) begin failures++; $display("FAIL full_done got=%b/%0d exp=1111/0", finished, dut.fifo_cnt); end
    checks++; if (logq.size() - base != 4 || logq[base+2] !== 32'hE2 || logq[base+3] !== 32'hE3) begin failures++; $display("FAIL full_order got=%0d exp=4", logq.size() - base); end
  endtask

  task automatic test_orphan_busy();
    int base;
    do_reset();
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'hDEAD;
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", err_orphan); end
    checks++; if (result !== 128'd0 || finished !== 4'hF) begin failures++; $display("FAIL orphan_res got=%h exp=0", result); end
    base = logq.size();
    dp.ready_dp = 1'b1;
    instruction[1*32 +: 32] = 32'h51;
    start = 4'b0010;
    tick(1);
    start = 4'h0;
    tick(2);
    instruction[1*32 +: 32] = 32'h52;
    start = 4'b0010;
    tick(1);
    start = 4'h0;
    tick(3);
    checks++; if (logq.size() - base != 1 || dp.start_dp !== 1'b0) begin failures++; $display("FAIL busy_ignore got=%0d exp=1", logq.size() - base); end
    checks++; if (finished !== 4'b1101) begin failures++; $display("FAIL busy_fin got=%b exp=1101", finished); end
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h61;
    instruction[1*32 +: 32] = 32'h53;
    start = 4'b0010;
    tick(1);
    dp.finished_dp = 1'b0;
    start = 4'h0;
    checks++; if (result[1*32 +: 32] !== 32'h61 || finished !== 4'hF) begin failures++; $display("FAIL ret_start_res got=%h/%b exp=61/1111", result[1*32 +: 32], finished); end
    tick(3);
    checks++; if (logq.size() - base != 1 || finished !== 4'hF) begin failures++; $display("FAIL ret_start_ign got=%0d/%b exp=1/1111", logq.size() - base, finished); end
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    dp.ready_dp = 1'b1;
    for (int p = 0; p < 3; p++) instruction[p*32 +: 32] = 32'h70 + p;
    start = 4'b0111;
    tick(1);
    start = 4'h0;
    tick(4);
    checks++; if (dut.fifo_cnt !== 2'd2) begin failures++; $display("FAIL mid_pre got=%0d exp=2", dut.fifo_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (dp.start_dp !== 1'b0 || dp.instruction_dp !== 32'd0) begin failures++; $display("FAIL mid_dp got=%b/%h exp=0/0", dp.start_dp, dp.instruction_dp); end
    checks++; if (finished !== 4'hF || result !== 128'd0 || err_orphan !== 1'b0) begin failures++; $display("FAIL mid_out got=%b/%h exp=1111/0", finished, result); end
    checks++; if (dut.fifo_cnt !== 2'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", dut.fifo_cnt); end
    tick(1);
    rst = 1'b0;
    tick(1);
    dp.finished_dp = 1'b1;
    dp.result_dp   = 32'h55;
    tick(1);
    dp.finished_dp = 1'b0;
    checks++; if (err_orphan !== 1'b1 || result !== 128'd0) begin failures++; $display("FAIL mid_late got=%b/%h exp=1/0", err_orphan, result); end
    checks++; if (dp.start_dp !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", dp.start_dp); end
  endtask

  initial begin
    rst            = 1'b1;
    instruction    = '0;
    start          = '0;
    dp.ready_dp    = 1'b0;
    dp.finished_dp = 1'b0;
    dp.result_dp   = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_fifo_full();
    test_orphan_busy();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
